alu_exec_responder: RTL and testbench



---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_exec_core.sv | 53 +++++
 rtl/alu_exec_responder.sv | 121 ++++++++++++
 tb/tb_alu_exec_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution responder: opcodes, FSM states, defaults.
// Optional overflow flag is enabled by defining ALU_EXEC_OVF_EN.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec_core.sv
// Combinational ALU core: result and carry/borrow for ADD/SUB/AND/OR.
// Defining ALU_EXEC_OVF_EN adds the signed-overflow output OF.
module alu_exec_core
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             CF
`ifdef ALU_EXEC_OVF_EN
  ,
  output logic             OF
`endif
);

  logic [WIDTH:0] ext;

  always_comb begin
    ext    = '0;
    result = '0;
    CF     = 1'b0;
    case (op)
      OP_ADD: begin
        ext    = {1'b0, a} + {1'b0, b};
        result = ext[WIDTH-1:0];
        CF     = ext[WIDTH];
      end
      OP_SUB: begin
        // The extra top bit of a zero-extended subtraction is the unsigned borrow.
        ext    = {1'b0, a} - {1'b0, b};
        result = ext[WIDTH-1:0];
        CF     = ext[WIDTH];
      end
      OP_AND: result = a & b;
      default: result = a | b;
    endcase
  end

`ifdef ALU_EXEC_OVF_EN
  always_comb begin
    OF = 1'b0;
    case (op)
      OP_ADD: OF = (a[WIDTH-1] == b[WIDTH-1]) & (result[WIDTH-1] != a[WIDTH-1]);
      OP_SUB: OF = (a[WIDTH-1] != b[WIDTH-1]) & (result[WIDTH-1] != a[WIDTH-1]);
      default: OF = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/alu_exec_responder.sv
// Command/response wrapper around alu_exec_core with a fixed EXEC latency.
// Defining ALU_EXEC_OVF_EN adds the registered overflow flag output OF.
module alu_exec_responder
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic             SF,
  output logic             CF,
  output logic             ZF,
  output logic             gt_zero_flag,
  output logic             busy
`ifdef ALU_EXEC_OVF_EN
  ,
  output logic             OF
`endif
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("alu_exec_responder: LATENCY must be >= 1");
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] core_result;
  logic             core_cf;
`ifdef ALU_EXEC_OVF_EN
  logic             core_of;
`endif

  alu_exec_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (core_result),
    .CF     (core_cf)
`ifdef ALU_EXEC_OVF_EN
    ,
    .OF     (core_of)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = EXEC;
      EXEC:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // Result and flags are only written on the last EXEC cycle, so they hold through RESP and IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      cnt          <= '0;
      result       <= '0;
      SF           <= 1'b0;
      CF           <= 1'b0;
      ZF           <= 1'b0;
      gt_zero_flag <= 1'b0;
`ifdef ALU_EXEC_OVF_EN
      OF           <= 1'b0;
`endif
    end else if (state == IDLE && cmd_valid) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
      cnt  <= CW'(LATENCY - 1);
    end else if (state == EXEC) begin
      if (cnt == '0) begin
        result       <= core_result;
        CF           <= core_cf;
        SF           <= core_result[WIDTH-1];
        ZF           <= (core_result == '0);
        gt_zero_flag <= ~core_result[WIDTH-1] & (core_result != '0);
`ifdef ALU_EXEC_OVF_EN
        OF           <= core_of;
`endif
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_responder.sv
// Self-checking bench for alu_exec_responder: directed cases plus random commands vs. an arithmetic model.
// Covers the OF output when ALU_EXEC_OVF_EN is defined.
module tb_alu_exec_responder;

  localparam int W    = 6;
  localparam int LAT  = 2;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] result;
  logic         SF;
  logic         CF;
  logic         ZF;
  logic         gt_zero_flag;
  logic         busy;
`ifdef ALU_EXEC_OVF_EN
  logic         OF;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  alu_exec_responder #(
    .WIDTH   (W),
    .LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .a            (a),
    .b            (b),
    .op           (op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .result       (result),
    .SF           (SF),
    .CF           (CF),
    .ZF           (ZF),
    .gt_zero_flag (gt_zero_flag),
    .busy         (busy)
`ifdef ALU_EXEC_OVF_EN
    ,
    .OF           (OF)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned and two's-complement integer arithmetic on plain ints.
  function automatic void model(input int ua, input int ub, input int uop,
                                output int r, output bit cf, output bit of);
    int sa, sb, t;
    sa = (ua >= HALF) ? ua - MOD : ua;
    sb = (ub >= HALF) ? ub - MOD : ub;
    r  = 0;
    cf = 1'b0;
    of = 1'b0;
    case (uop)
      0: begin
        t  = ua + ub;
        r  = t % MOD;
        cf = (t >= MOD);
        t  = sa + sb;
        of = (t >= HALF) || (t < -HALF);
      end
      1: begin
        r  = (ua - ub + MOD) % MOD;
        cf = (ua < ub);
        t  = sa - sb;
        of = (t >= HALF) || (t < -HALF);
      end
      2: r = ua & ub;
      default: r = ua | ub;
    endcase
  endfunction

  task automatic run_cmd(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [1:0] top, input int hold);
    int er, lat;
    bit ecf, eof;
    model(int'(ta), int'(tb_v), int'(top), er, ecf, eof);
    chk("ready_before_cmd", cmd_ready, 1);
    a = ta; b = tb_v; op = top; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("ready_after_accept", cmd_ready, 0);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", lat, LAT);
    chk("result", result, er);
    chk("cf", CF, ecf);
    chk("sf", SF, (er >= HALF));
    chk("zf", ZF, (er == 0));
    chk("gt_zero", gt_zero_flag, (er != 0) && (er < HALF));
`ifdef ALU_EXEC_OVF_EN
    chk("of", OF, eof);
`endif
    for (int i = 0; i < hold; i++) begin
      cmd_valid = (i == 1);
      if (i == 1) begin a = W'($urandom); b = W'($urandom); op = 2'($urandom); end
      step();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", result, er);
      chk("hold_cf", CF, ecf);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("release_valid", rsp_valid, 0);
    chk("release_cmd_ready", cmd_ready, 1);
    chk("release_busy", busy, 0);
    chk("release_result_kept", result, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    a = '0; b = '0; op = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {SF, CF, ZF, gt_zero_flag}, 0);
`ifdef ALU_EXEC_OVF_EN
    chk("rst_of", OF, 0);
`endif

    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_rsp_ready_ignored", {busy, rsp_valid}, 0);
    end
    rsp_ready = 1'b0;

    run_cmd(6'b110011, 6'b101010, 2'b00, 0);
    chk("add_carry_result", result, 6'b011101);
    chk("add_carry_cf", CF, 1);

    run_cmd(6'b110011, 6'b000001, 2'b01, 1);
    chk("sub_noborrow_result", result, 6'b110010);
    chk("sub_noborrow_cf", CF, 0);

    run_cmd(6'b000001, 6'b000010, 2'b01, 0);
    chk("sub_borrow_result", result, 6'b111111);
    chk("sub_borrow_cf", CF, 1);

    // Reset the cycle after accept: no response may ever appear.
    a = 6'b000111; b = 6'b000011; op = 2'b00; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_result", result, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_no_rsp", rsp_valid, 0);
    end
    run_cmd(6'b000111, 6'b000011, 2'b00, 0);

    run_cmd(6'b000000, 6'b000000, 2'b00, 5);
    chk("zero_zf", ZF, 1);

    run_cmd(6'b011111, 6'b000001, 2'b00, 0);
    chk("ovf_add_result", result, 6'b100000);
    chk("ovf_add_sf", SF, 1);
`ifdef ALU_EXEC_OVF_EN
    chk("ovf_add_of", OF, 1);
`endif
    run_cmd(6'b011111, 6'b000001, 2'b10, 0);
`ifdef ALU_EXEC_OVF_EN
    chk("ovf_and_of", OF, 0);
`endif
    run_cmd(6'b111111, 6'b111111, 2'b00, 2);
    run_cmd(6'b000000, 6'b111111, 2'b01, 0);
    run_cmd(6'b100000, 6'b000001, 2'b01, 1);

    for (int n = 0; n < 40; n++) begin
      run_cmd(W'($urandom), W'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
